ddc_acc_serializer: RTL and testbench
=====================================

Name: ddc_acc_serializer

Overview:
- Next-generation integrate-and-dump stage for the octal DDC path.
- Accumulates N_CH complex DDC streams (I and Q) over a programmable length.
- Snapshots every finished frame into a frame FIFO, then serializes it one channel per beat onto an AXI4-Stream master.
- Adds full tready backpressure, channel tagging, a frame drop counter and resync handling. The previous generation had none of these.

Parameters:
N_CH, 4, number of DDC channels (>=1, need not be a power of 2)
DIN_WIDTH, 32, signed width of each I or Q input sample
ACC_WIDTH, 48, signed accumulator width per I/Q (>= DIN_WIDTH)
LEN_WIDTH, 32, width of accumulation length
FIFO_DEPTH, 4, number of whole frames buffered (power of 2, >=2)

Ports:
clk  in  1  single clock for all logic
rst  in  1  asynchronous, active-high reset
din_valid  in  1  one sample per channel valid this cycle
din_data  in  N_CH*2*DIN_WIDTH  channel k occupies [k*2*DIN_WIDTH +: 2*DIN_WIDTH], layout {Q,I}
length  in  LEN_WIDTH  samples per frame, sampled at frame start
resync  in  1  restart accumulation (level, acts per cycle)
m_axis_tdata  out  2*ACC_WIDTH  {Q_acc, I_acc} of one channel
m_axis_tuser  out  max(1,$clog2(N_CH))  channel index of current beat
m_axis_tlast  out  1  high on channel N_CH-1 beat
m_axis_tvalid  out  1  AXIS valid
m_axis_tready  in  1  AXIS ready
frame_cnt  out  32  frames pushed to FIFO, wraps
drop_cnt  out  16  frames dropped on FIFO full, saturates at 0xFFFF

Behaviour:
Reset:
- rst asserted: all accumulators, sample counter, FIFO pointers, occupancy, counters, m_axis_tvalid, m_axis_tlast and m_axis_tuser go to 0 immediately; m_axis_tdata goes to 0.
- FSM enters IDLE. len_q is loaded with 1.

Accumulate:
- len_q = max(length,1), latched on the first accepted sample of each frame.
- Each din_valid cycle: acc_k <= (first ? 0 : acc_k) + sext(sample_k).
- Sample counter increments and compares to len_q-1.
- Last sample (counter == len_q-1 with din_valid): the frame value is acc_k + sample_k. It is written to the FIFO the same edge. The accumulator restarts on the next valid sample with no dead cycles.
- length = 1 dumps every valid sample.

Resync:
- Clears the counter and marks the next sample as first.
- If resync and a last sample coincide, resync wins and no frame is pushed.
- FIFO contents and the serializer are unaffected.

Push rules:
- Push succeeds if occupancy < FIFO_DEPTH, or if a pop completes in the same cycle.
- Otherwise the frame is dropped and drop_cnt increments (saturating); frame_cnt is not incremented.

Serializer FSM:
- IDLE -> SEND when occupancy > 0 (evaluated on registered occupancy).
- SEND: ch_idx runs from 0 to N_CH-1.
  - Registered output; tvalid=1; tdata = head frame channel ch_idx; tuser = ch_idx; tlast = (ch_idx==N_CH-1).
  - A beat advances only on tvalid&tready; outputs are held stable while tready=0.
  - After the last beat: pop the head frame. Go to SEND with ch_idx=0 if more frames remain (back-to-back, no bubble), else to IDLE with tvalid=0.

Latency:
- Last sample at edge t -> frame in FIFO after edge t -> tvalid=1 after edge t+1 when IDLE.
- Sustained throughput is one beat per cycle. Frames arriving faster than every N_CH valid cycles eventually drop.

Arithmetic:
- Two's complement throughout. Inputs are sign-extended to ACC_WIDTH.
- Without the optional feature, overflow wraps modulo 2^ACC_WIDTH.

Optional Feature:
- Macro: DDC_ACC_SAT_EN.
- Defined: each add saturates to the signed range of ACC_WIDTH, i.e. [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1]. Saturation holds for the rest of the frame unless a later add brings the value back within range.
- Not defined: plain wrapping add, and no saturation logic is generated.

Decomposition:
- Package ddc_acc_pkg holds:
  - function clog2_min1 (used for the tuser width)
  - localparams FRAME_W = N_CH*2*ACC_WIDTH and BEAT_W = 2*ACC_WIDTH
  - saturating-add function used under DDC_ACC_SAT_EN
- One sub-module, ddc_frame_fifo: synchronous FIFO of FIFO_DEPTH x FRAME_W.
  - Ports: push, pop, full, empty, count.
  - Head data is readable combinationally.
  - Uses the same clk/rst.

Test Plan:
- N_CH=4, length=4, din all channels I=1 Q=-1 continuous, tready=1 -> 4-beat frames every 4 cycles; tdata I=4, Q=-4; tuser 0,1,2,3; tlast on beat 4; frame_cnt increments; drop_cnt=0.
- length=0, channel k I=k+1 Q=0, continuous, tready=1 -> treated as 1; frames of {0,1..4}; FIFO fills; drops begin at 4 frames in flight; drop_cnt counts while frame_cnt+drop_cnt matches the dump count.
- length=8, tready=0 for 100 cycles, then 1 -> tvalid held with tdata/tuser stable; 4 frames kept (FIFO_DEPTH=4); further frames counted in drop_cnt; buffered frames drain in order with correct sums.
- resync asserted on the 3rd sample of a length-5 frame, input I=2 -> no frame output for the aborted frame; next frame I=10 counted from the sample after resync; resync coinciding with a last sample pushes nothing.
- rst asserted mid-SEND after beat 1 -> tvalid=0 and counters=0 immediately; after release, the first output frame contains only samples received after reset.
- DDC_ACC_SAT_EN, ACC_WIDTH=33, DIN_WIDTH=32, I=0x7FFFFFFF, length=4 -> I_acc=0x0FFFFFFFF (max); without the macro -> wrapped value 0x1FFFFFFFC.

Source files
------------

// File: rtl/ddc_acc_pkg.sv
// Shared types, default widths and arithmetic helpers for the DDC integrate-and-dump serializer.
package ddc_acc_pkg;
  localparam int DEF_N_CH      = 4;
  localparam int DEF_ACC_WIDTH = 48;
  localparam int FRAME_W       = DEF_N_CH * 2 * DEF_ACC_WIDTH;
  localparam int BEAT_W        = 2 * DEF_ACC_WIDTH;
  localparam int SAT_W         = 64;

  typedef enum logic {ST_IDLE = 1'b0, ST_SEND = 1'b1} ser_state_e;

  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 << i) < n) r = i + 1;
      else r = r;
    end
    return (r < 1) ? 1 : r;
  endfunction

  // Operands arrive sign-extended to SAT_W; result is clamped to a w-bit signed range.
  function automatic logic [SAT_W-1:0] sat_add(input logic [SAT_W-1:0] a,
                                               input logic [SAT_W-1:0] b,
                                               input int w);
    logic signed [SAT_W:0] sum;
    logic signed [SAT_W:0] max_v;
    logic signed [SAT_W:0] min_v;
    sum   = $signed({a[SAT_W-1], a}) + $signed({b[SAT_W-1], b});
    max_v = (65'sd1 <<< (w - 1)) - 65'sd1;
    min_v = -(65'sd1 <<< (w - 1));
    if (sum > max_v) return max_v[SAT_W-1:0];
    else if (sum < min_v) return min_v[SAT_W-1:0];
    else return sum[SAT_W-1:0];
  endfunction
endpackage

// File: rtl/ddc_frame_fifo.sv
// Whole-frame FIFO; head and the entry behind it are readable combinationally.
module ddc_frame_fifo
  import ddc_acc_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = FRAME_W,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wr_data_i,
  output logic [WIDTH-1:0] head_data_o,
  output logic [WIDTH-1:0] next_data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push_s, do_pop_s;

  // A push into a full FIFO is legal when the head leaves on the same edge.
  assign do_pop_s  = pop_i && (count_q != '0);
  assign do_push_s = push_i && ((count_q != CNT_W'(DEPTH)) || do_pop_s);

  always_comb begin
    wr_ptr_d = do_push_s ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop_s ? rd_ptr_q + PW'(1) : rd_ptr_q;
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push_s) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign head_data_o = mem_q[rd_ptr_q];
  assign next_data_o = mem_q[rd_ptr_q + PW'(1)];
  assign full_o      = (count_q == CNT_W'(DEPTH));
  assign empty_o     = (count_q == '0);
  assign count_o     = count_q;
endmodule

// File: rtl/ddc_acc_serializer.sv
// Multi-channel complex integrate-and-dump with frame FIFO and AXI4-Stream serializer.
// Optional macro DDC_ACC_SAT_EN: saturating accumulation instead of wrapping.
module ddc_acc_serializer
  import ddc_acc_pkg::*;
#(
  parameter int N_CH       = 4,
  parameter int DIN_WIDTH  = 32,
  parameter int ACC_WIDTH  = 48,
  parameter int LEN_WIDTH  = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          din_valid,
  input  logic [N_CH*2*DIN_WIDTH-1:0]   din_data,
  input  logic [LEN_WIDTH-1:0]          length,
  input  logic                          resync,
  output logic [2*ACC_WIDTH-1:0]        m_axis_tdata,
  output logic [clog2_min1(N_CH)-1:0]   m_axis_tuser,
  output logic                          m_axis_tlast,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic [31:0]                   frame_cnt,
  output logic [15:0]                   drop_cnt
);
  localparam int UW         = clog2_min1(N_CH);
  localparam int BEAT_BITS  = 2 * ACC_WIDTH;
  localparam int FRAME_BITS = N_CH * BEAT_BITS;
  localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [UW-1:0] LAST_CH = UW'(N_CH - 1);

  typedef logic [N_CH-1:0][1:0][ACC_WIDTH-1:0] acc_arr_t;
  typedef logic [N_CH-1:0][1:0][DIN_WIDTH-1:0] din_arr_t;

  din_arr_t                 din_s;
  acc_arr_t                 acc_q, acc_d, sum_s;
  logic [LEN_WIDTH-1:0]     cnt_q, cnt_d, len_q, len_d, len_eff_s;
  logic                     first_q, first_d, push_req_s, push_ok_s, drop_s;
  logic [31:0]              frame_cnt_q, frame_cnt_d;
  logic [15:0]              drop_cnt_q, drop_cnt_d;
  ser_state_e               state_q, state_d;
  logic [UW-1:0]            ch_q, ch_d, ch_nxt_s, tuser_q, tuser_d;
  logic                     tvalid_q, tvalid_d, tlast_q, tlast_d;
  logic [BEAT_BITS-1:0]     tdata_q, tdata_d;
  logic                     pop_s, fifo_full_s, fifo_empty_s;
  logic [CNT_W-1:0]         fifo_count_s;
  logic [FRAME_BITS-1:0]    head_flat_s, next_flat_s;
  logic [N_CH-1:0][BEAT_BITS-1:0] head_s, next_s;

  assign din_s  = din_data;
  assign head_s = head_flat_s;
  assign next_s = next_flat_s;

  always_comb begin
    sum_s = '0;
    for (int k = 0; k < N_CH; k++) begin
      for (int j = 0; j < 2; j++) begin
        logic [ACC_WIDTH-1:0] base_v;
        base_v = first_q ? '0 : acc_q[k][j];
`ifdef DDC_ACC_SAT_EN
        sum_s[k][j] = ACC_WIDTH'(sat_add(SAT_W'($signed(base_v)),
                                         SAT_W'($signed(din_s[k][j])), ACC_WIDTH));
`else
        sum_s[k][j] = base_v + ACC_WIDTH'($signed(din_s[k][j]));
`endif
      end
    end
  end

  // Resync has priority over any sample, including a frame's last one.
  always_comb begin
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    first_d    = first_q;
    push_req_s = 1'b0;
    len_eff_s  = first_q ? ((length == '0) ? LEN_WIDTH'(1) : length) : len_q;
    if (resync) begin
      cnt_d   = '0;
      first_d = 1'b1;
    end else if (din_valid) begin
      acc_d = sum_s;
      len_d = len_eff_s;
      if (cnt_q == len_eff_s - LEN_WIDTH'(1)) begin
        push_req_s = 1'b1;
        cnt_d      = '0;
        first_d    = 1'b1;
      end else begin
        cnt_d   = cnt_q + LEN_WIDTH'(1);
        first_d = 1'b0;
      end
    end else begin
      first_d = first_q;
    end
  end

  assign push_ok_s   = push_req_s && (!fifo_full_s || pop_s);
  assign drop_s      = push_req_s && !push_ok_s;
  assign frame_cnt_d = push_ok_s ? frame_cnt_q + 32'd1 : frame_cnt_q;
  assign drop_cnt_d  = (drop_s && (drop_cnt_q != 16'hFFFF)) ? drop_cnt_q + 16'd1 : drop_cnt_q;

  ddc_frame_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (FRAME_BITS),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push_ok_s),
    .pop_i       (pop_s),
    .wr_data_i   (sum_s),
    .head_data_o (head_flat_s),
    .next_data_o (next_flat_s),
    .full_o      (fifo_full_s),
    .empty_o     (fifo_empty_s),
    .count_o     (fifo_count_s)
  );

  // Back-to-back frames load beat 0 from the entry behind the head being popped.
  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    tvalid_d = tvalid_q;
    tdata_d  = tdata_q;
    tuser_d  = tuser_q;
    tlast_d  = tlast_q;
    pop_s    = 1'b0;
    ch_nxt_s = ch_q + UW'(1);
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty_s) begin
          state_d  = ST_SEND;
          ch_d     = '0;
          tvalid_d = 1'b1;
          tdata_d  = head_s[0];
          tuser_d  = '0;
          tlast_d  = (N_CH == 1) ? 1'b1 : 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SEND: begin
        if (tvalid_q && m_axis_tready) begin
          if (ch_q == LAST_CH) begin
            pop_s = 1'b1;
            if (fifo_count_s > CNT_W'(1)) begin
              ch_d    = '0;
              tdata_d = next_s[0];
              tuser_d = '0;
              tlast_d = (N_CH == 1) ? 1'b1 : 1'b0;
            end else begin
              state_d  = ST_IDLE;
              ch_d     = '0;
              tvalid_d = 1'b0;
              tdata_d  = '0;
              tuser_d  = '0;
              tlast_d  = 1'b0;
            end
          end else begin
            ch_d    = ch_nxt_s;
            tdata_d = head_s[ch_nxt_s];
            tuser_d = ch_nxt_s;
            tlast_d = (ch_nxt_s == LAST_CH);
          end
        end else begin
          state_d = ST_SEND;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        tvalid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      len_q       <= LEN_WIDTH'(1);
      first_q     <= 1'b1;
      frame_cnt_q <= 32'd0;
      drop_cnt_q  <= 16'd0;
      state_q     <= ST_IDLE;
      ch_q        <= '0;
      tvalid_q    <= 1'b0;
      tdata_q     <= '0;
      tuser_q     <= '0;
      tlast_q     <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      first_q     <= first_d;
      frame_cnt_q <= frame_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
      state_q     <= state_d;
      ch_q        <= ch_d;
      tvalid_q    <= tvalid_d;
      tdata_q     <= tdata_d;
      tuser_q     <= tuser_d;
      tlast_q     <= tlast_d;
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tuser  = tuser_q;
  assign m_axis_tlast  = tlast_q;
  assign m_axis_tvalid = tvalid_q;
  assign frame_cnt     = frame_cnt_q;
  assign drop_cnt      = drop_cnt_q;
endmodule

// File: tb/tb_ddc_acc_serializer.sv
// Scoreboard bench for ddc_acc_serializer (N_CH=4, ACC_WIDTH=33 so wrap/saturation is reachable).
module tb_ddc_acc_serializer;
  localparam int N_CH   = 4;
  localparam int DIN_W  = 32;
  localparam int ACC_W  = 33;
  localparam int LEN_W  = 32;
  localparam int BEAT_W = 2 * ACC_W;

  logic                      clk = 1'b0;
  logic                      rst = 1'b0;
  logic                      din_valid = 1'b0;
  logic [N_CH*2*DIN_W-1:0]   din_data = '0;
  logic [LEN_W-1:0]          length = '0;
  logic                      resync = 1'b0;
  logic [BEAT_W-1:0]         tdata;
  logic [1:0]                tuser;
  logic                      tlast, tvalid;
  logic                      tready = 1'b0;
  logic [31:0]               frame_cnt;
  logic [15:0]               drop_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [BEAT_W-1:0] data;
    logic [1:0]        user;
    logic              last;
  } beat_t;

  beat_t exp_q[$];
  beat_t exp_b;
  bit    mon_en = 1'b0;
  bit    mon_const = 1'b0;
  int    beats_seen = 0;

  logic [ACC_W-1:0] m_acc [N_CH][2];
  int m_cnt = 0;
  int m_len = 1;
  bit m_first = 1'b1;

  ddc_acc_serializer #(
    .N_CH (N_CH), .DIN_WIDTH (DIN_W), .ACC_WIDTH (ACC_W), .LEN_WIDTH (LEN_W), .FIFO_DEPTH (4)
  ) dut (
    .clk (clk), .rst (rst), .din_valid (din_valid), .din_data (din_data), .length (length),
    .resync (resync), .m_axis_tdata (tdata), .m_axis_tuser (tuser), .m_axis_tlast (tlast),
    .m_axis_tvalid (tvalid), .m_axis_tready (tready), .frame_cnt (frame_cnt), .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [ACC_W-1:0] add_model(input logic [ACC_W-1:0] a, input logic [DIN_W-1:0] s);
    longint sum, max_v, min_v;
    sum   = longint'($signed(a)) + longint'($signed(s));
    max_v = (64'sd1 <<< (ACC_W - 1)) - 64'sd1;
    min_v = -(64'sd1 <<< (ACC_W - 1));
`ifdef DDC_ACC_SAT_EN
    if (sum > max_v) sum = max_v;
    else if (sum < min_v) sum = min_v;
`endif
    return sum[ACC_W-1:0];
  endfunction

  function automatic logic [N_CH*2*DIN_W-1:0] din_all(input logic [31:0] i_v, input logic [31:0] q_v);
    logic [N_CH*2*DIN_W-1:0] d;
    for (int c = 0; c < N_CH; c++) begin
      d[(2*c)*DIN_W +: DIN_W]   = i_v;
      d[(2*c+1)*DIN_W +: DIN_W] = q_v;
    end
    return d;
  endfunction

  // Drive one cycle and advance the reference accumulator.
  task automatic drive_cycle(input bit v, input bit rs, input logic [N_CH*2*DIN_W-1:0] d, output bit dumped);
    dumped    = 1'b0;
    din_valid = v;
    resync    = rs;
    din_data  = d;
    if (rs) begin
      m_cnt   = 0;
      m_first = 1'b1;
    end else if (v) begin
      if (m_first) m_len = (length == '0) ? 1 : int'(length);
      for (int c = 0; c < N_CH; c++)
        for (int j = 0; j < 2; j++)
          m_acc[c][j] = add_model(m_first ? '0 : m_acc[c][j], d[(2*c+j)*DIN_W +: DIN_W]);
      m_cnt++;
      m_first = 1'b0;
      if (m_cnt == m_len) begin
        dumped  = 1'b1;
        m_cnt   = 0;
        m_first = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame();
    beat_t b;
    for (int c = 0; c < N_CH; c++) begin
      b.data = {m_acc[c][1], m_acc[c][0]};
      b.user = 2'(c);
      b.last = (c == N_CH - 1);
      exp_q.push_back(b);
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    din_valid = 1'b0;
    resync    = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !tvalid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    rst = 1'b1;
    din_valid = 1'b0;
    resync = 1'b0;
    exp_q.delete();
    m_cnt = 0;
    m_first = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    mon_en = 1'b1;
  endtask

  // Scoreboard monitor: every accepted beat is compared against the expected queue.
  always @(negedge clk) begin
    if (mon_en && !rst && tvalid && tready) begin
      beats_seen++;
      checks++;
      if (mon_const) begin
        if (tdata !== {33'd0, 33'(tuser) + 33'd1} || tlast !== (tuser == 2'd3)) begin
          errors++;
          $display("FAIL const_beat: tdata=%h tuser=%0d tlast=%b, required I=%0d Q=0 tlast=%b",
                   tdata, tuser, tlast, tuser + 1, (tuser == 2'd3));
        end
      end else if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_beat: tdata=%h tuser=%0d, required no beat", tdata, tuser);
      end else begin
        exp_b = exp_q.pop_front();
        if (tdata !== exp_b.data || tuser !== exp_b.user || tlast !== exp_b.last) begin
          errors++;
          $display("FAIL beat: got tdata=%h tuser=%0d tlast=%b, required tdata=%h tuser=%0d tlast=%b",
                   tdata, tuser, tlast, exp_b.data, exp_b.user, exp_b.last);
        end
      end
    end
  end

  task automatic test_reset();
    #2 rst = 1'b1;
    #1;
    checks++;
    if (tvalid !== 1'b0 || tlast !== 1'b0 || tuser !== 2'd0 || tdata !== '0) begin
      errors++;
      $display("FAIL reset_axis: tvalid=%b tlast=%b tuser=%0d tdata=%h, required all 0", tvalid, tlast, tuser, tdata);
    end
    checks++;
    if (frame_cnt !== 32'd0 || drop_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_counters: frame_cnt=%0d drop_cnt=%0d, required 0 0", frame_cnt, drop_cnt);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (tvalid !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: tvalid=%b, required 0", tvalid);
    end
  endtask

  task automatic test_basic();
    bit dumped, ok;
    do_reset();
    tready = 1'b1;
    length = 32'd4;
    for (int i = 0; i < 16; i++) begin
      drive_cycle(1'b1, 1'b0, din_all(32'd1, 32'hFFFFFFFF), dumped);
      if (dumped) push_frame();
      if (i == 3) begin
        checks++;
        if (tvalid !== 1'b0) begin
          errors++;
          $display("FAIL latency_t: tvalid=%b one edge after last sample, required 0", tvalid);
        end
      end
      if (i == 4) begin
        checks++;
        if (tvalid !== 1'b1 || tuser !== 2'd0) begin
          errors++;
          $display("FAIL latency_t1: tvalid=%b tuser=%0d two edges after last sample, required 1 0", tvalid, tuser);
        end
      end
    end
    wait_idle(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL basic_drain: %0d beats left, required 0", exp_q.size());
    end
    checks++;
    if (frame_cnt !== 32'd4 || drop_cnt !== 16'd0) begin
      errors++;
      $display("FAIL basic_counts: frame_cnt=%0d drop_cnt=%0d, required 4 0", frame_cnt, drop_cnt);
    end
  endtask

  task automatic test_length_zero();
    bit dumped, ok;
    int dumps;
    logic [N_CH*2*DIN_W-1:0] d;
    do_reset();
    tready = 1'b1;
    length = 32'd0;
    mon_const = 1'b1;
    beats_seen = 0;
    dumps = 0;
    for (int c = 0; c < N_CH; c++) begin
      d[(2*c)*DIN_W +: DIN_W]   = 32'(c + 1);
      d[(2*c+1)*DIN_W +: DIN_W] = 32'd0;
    end
    for (int i = 0; i < 40; i++) begin
      drive_cycle(1'b1, 1'b0, d, dumped);
      if (dumped) dumps++;
    end
    wait_idle(ok);
    mon_const = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL len0_drain: tvalid=%b, required 0", tvalid);
    end
    checks++;
    if (int'(frame_cnt) + int'(drop_cnt) != dumps || dumps != 40) begin
      errors++;
      $display("FAIL len0_sum: frame_cnt+drop_cnt=%0d, required %0d (dumps 40)", frame_cnt + drop_cnt, dumps);
    end
    checks++;
    if (drop_cnt == 16'd0) begin
      errors++;
      $display("FAIL len0_drops: drop_cnt=%0d, required nonzero", drop_cnt);
    end
    checks++;
    if (beats_seen != 4 * int'(frame_cnt)) begin
      errors++;
      $display("FAIL len0_beats: beats=%0d, required %0d", beats_seen, 4 * frame_cnt);
    end
  endtask

  task automatic test_backpressure();
    bit dumped, ok;
    int nframes;
    logic [BEAT_W-1:0] cap_data;
    logic [1:0] cap_user;
    logic [N_CH*2*DIN_W-1:0] d;
    do_reset();
    tready = 1'b0;
    length = 32'd8;
    nframes = 0;
    cap_data = '0;
    cap_user = '0;
    for (int j = 1; j <= 100; j++) begin
      for (int c = 0; c < N_CH; c++) begin
        d[(2*c)*DIN_W +: DIN_W]   = 32'(j + c);
        d[(2*c+1)*DIN_W +: DIN_W] = 32'(-j);
      end
      drive_cycle(1'b1, 1'b0, d, dumped);
      if (dumped) begin
        if (nframes < 4) push_frame();
        nframes++;
      end
      if (j == 50) begin
        cap_data = tdata;
        cap_user = tuser;
      end
    end
    checks++;
    if (tvalid !== 1'b1 || tdata !== cap_data || tuser !== cap_user || tuser !== 2'd0) begin
      errors++;
      $display("FAIL hold_stable: tvalid=%b tdata=%h tuser=%0d, required 1 %h 0", tvalid, tdata, tuser, cap_data);
    end
    checks++;
    if (tdata !== exp_q[0].data) begin
      errors++;
      $display("FAIL hold_value: tdata=%h, required %h", tdata, exp_q[0].data);
    end
    checks++;
    if (frame_cnt !== 32'd4 || int'(drop_cnt) != nframes - 4) begin
      errors++;
      $display("FAIL bp_counts: frame_cnt=%0d drop_cnt=%0d, required 4 %0d", frame_cnt, drop_cnt, nframes - 4);
    end
    tready = 1'b1;
    wait_idle(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL bp_drain: %0d beats left, required 0", exp_q.size());
    end
  endtask

  task automatic test_resync();
    bit dumped, ok;
    do_reset();
    tready = 1'b1;
    length = 32'd5;
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b1, (i == 2), din_all(32'd2, 32'd0), dumped);
      if (dumped) push_frame();
    end
    for (int i = 0; i < 5; i++) begin
      drive_cycle(1'b1, 1'b0, din_all(32'd10, 32'd0), dumped);
      if (dumped) push_frame();
    end
    for (int i = 0; i < 5; i++) begin
      drive_cycle(1'b1, (i == 4), din_all(32'd3, 32'd0), dumped);
      if (dumped) push_frame();
    end
    for (int i = 0; i < 5; i++) begin
      drive_cycle(1'b1, 1'b0, din_all(32'd1, 32'd0), dumped);
      if (dumped) push_frame();
    end
    wait_idle(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL resync_drain: %0d beats left, required 0", exp_q.size());
    end
    checks++;
    if (frame_cnt !== 32'd2) begin
      errors++;
      $display("FAIL resync_frames: frame_cnt=%0d, required 2", frame_cnt);
    end
  endtask

  task automatic test_reset_mid_send();
    bit dumped, ok, seen;
    do_reset();
    tready = 1'b1;
    length = 32'd1;
    drive_cycle(1'b1, 1'b0, din_all(32'd7, 32'd0), dumped);
    if (dumped) push_frame();
    din_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (tvalid && tuser == 2'd1) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL mid_send_reach: tvalid=%b tuser=%0d, required beat 1 on bus", tvalid, tuser);
    end
    #1;
    mon_en = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if (tvalid !== 1'b0 || tuser !== 2'd0 || tdata !== '0 || frame_cnt !== 32'd0 || drop_cnt !== 16'd0) begin
      errors++;
      $display("FAIL async_reset: tvalid=%b tuser=%0d tdata=%h frame_cnt=%0d drop_cnt=%0d, required all 0",
               tvalid, tuser, tdata, frame_cnt, drop_cnt);
    end
    exp_q.delete();
    m_cnt = 0;
    m_first = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    mon_en = 1'b1;
    length = 32'd2;
    for (int i = 0; i < 2; i++) begin
      drive_cycle(1'b1, 1'b0, din_all(32'd4, 32'hFFFFFFFE), dumped);
      if (dumped) push_frame();
    end
    wait_idle(ok);
    checks++;
    if (!ok || frame_cnt !== 32'd1) begin
      errors++;
      $display("FAIL post_reset_frame: pending=%0d frame_cnt=%0d, required 0 1", exp_q.size(), frame_cnt);
    end
  endtask

  task automatic test_saturation();
    bit dumped, ok, seen;
    logic [ACC_W-1:0] exp_i, exp_qv;
`ifdef DDC_ACC_SAT_EN
    exp_i  = 33'h0FFFFFFFF;
    exp_qv = 33'h100000000;
`else
    exp_i  = 33'h1FFFFFFFC;
    exp_qv = 33'h000000000;
`endif
    do_reset();
    tready = 1'b1;
    length = 32'd4;
    for (int i = 0; i < 4; i++) begin
      drive_cycle(1'b1, 1'b0, din_all(32'h7FFFFFFF, 32'h80000000), dumped);
      if (dumped) push_frame();
    end
    din_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (tvalid) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    checks++;
    if (!seen || tdata[ACC_W-1:0] !== exp_i || tdata[BEAT_W-1:ACC_W] !== exp_qv) begin
      errors++;
      $display("FAIL arith_edge: tvalid=%b I=%h Q=%h, required I=%h Q=%h",
               tvalid, tdata[ACC_W-1:0], tdata[BEAT_W-1:ACC_W], exp_i, exp_qv);
    end
    wait_idle(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL arith_drain: %0d beats left, required 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_length_zero();
    test_backpressure();
    test_resync();
    test_reset_mid_send();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end
endmodule
